// File: rtl/reverb_param_bank_if.sv
// Interface bundle for reverb_param_bank: encoder and HPS inputs, the flat
// register bank and the ready/valid change-event stream.
interface reverb_param_bank_if #(
    parameter int NUM_PARAMS = 4,
    parameter int DATA_W     = 24,
    parameter int SEL_W      = 4
);
    logic [SEL_W-1:0]             param_sel;
    logic [1:0]                   update;
    logic                         wr_en;
    logic [SEL_W-1:0]             wr_idx;
    logic [DATA_W-1:0]            wr_data;
    logic [NUM_PARAMS*DATA_W-1:0] param_values;
    logic                         evt_valid;
    logic                         evt_ready;
    logic [SEL_W-1:0]             evt_idx;
    logic [DATA_W-1:0]            evt_data;

    modport master (
        output param_sel, update, wr_en, wr_idx, wr_data, evt_ready,
        input  param_values, evt_valid, evt_idx, evt_data
    );

    modport slave (
        input  param_sel, update, wr_en, wr_idx, wr_data, evt_ready,
        output param_values, evt_valid, evt_idx, evt_data
    );
endinterface

// File: rtl/reverb_param_bank.sv
// reverb_param_bank: NUM_PARAMS saturating reverb control registers stepped
// by synchronised encoder pulses or written directly by the HPS. Every value
// change is reported once, lowest index first, on a ready/valid stream.
// Optional macro PARAM_ACCEL_EN: after three consecutive same-direction steps
// on the same index inside ACCEL_WINDOW cycles, steps grow to STEP<<2.
module reverb_param_bank #(
    parameter int                NUM_PARAMS   = 4,
    parameter int                DATA_W       = 24,
    parameter int                SEL_W        = 4,
    parameter logic [DATA_W-1:0] STEP         = 24'h010000,
    parameter logic [DATA_W-1:0] MAX_VAL      = 24'hFFFFFF,
    parameter logic [DATA_W-1:0] RESET_VAL    = 24'h800000,
    parameter int                ACCEL_WINDOW = 2_000_000
) (
    input  logic              clk,
    input  logic              reset,
    reverb_param_bank_if.slave bus
);

    // Parameter sanity: the select width must address every register and the
    // acceleration window must be non-empty.
    if ((ACCEL_WINDOW < 1) || ((1 << SEL_W) < NUM_PARAMS)) begin : g_badParams
        $error("reverb_param_bank: inconsistent parameters");
    end

    typedef enum logic {
        IDLE,
        PRESENT
    } emitState_t;

    logic [DATA_W-1:0]            r_regs [NUM_PARAMS];
    logic [NUM_PARAMS-1:0]        r_pending;
    logic [1:0]                   r_sync1;
    logic [1:0]                   r_sync2;
    logic [1:0]                   r_sync3;
    emitState_t                   r_state;
    emitState_t                   w_stateNext;
    logic                         r_evtValid;
    logic [SEL_W-1:0]             r_evtIdx;
    logic [DATA_W-1:0]            r_evtData;

    logic                         w_riseInc;
    logic                         w_riseDec;
    logic                         w_selInRange;
    logic                         w_encStep;
    logic                         w_encIsDec;
    logic                         w_wrHit;
    logic [DATA_W-1:0]            w_wrClamped;
    logic [DATA_W-1:0]            w_step;
    logic [DATA_W-1:0]            w_nextVal [NUM_PARAMS];
    logic [NUM_PARAMS-1:0]        w_changed;
    logic                         w_found;
    logic [SEL_W-1:0]             w_lowIdx;
    logic [DATA_W-1:0]            w_lowData;
    logic [NUM_PARAMS-1:0]        w_lowMask;
    logic [NUM_PARAMS-1:0]        w_clearMask;
    logic                         w_load;
    logic [NUM_PARAMS*DATA_W-1:0] w_flat;

    // Two-flop synchroniser per encoder bit plus a history flop for edge detect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_sync3 <= 2'b00;
        end else begin
            r_sync1 <= bus.update;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_riseInc    = r_sync2[0] & ~r_sync3[0];
    assign w_riseDec    = r_sync2[1] & ~r_sync3[1];
    assign w_selInRange = (32'(bus.param_sel) < NUM_PARAMS);
    assign w_encStep    = (w_riseInc ^ w_riseDec) & w_selInRange;
    assign w_encIsDec   = w_riseDec;
    assign w_wrHit      = bus.wr_en & (32'(bus.wr_idx) < NUM_PARAMS);
    assign w_wrClamped  = (bus.wr_data > MAX_VAL) ? MAX_VAL : bus.wr_data;

`ifdef PARAM_ACCEL_EN
    localparam int TIMER_W = $clog2(ACCEL_WINDOW + 1);

    logic [2:0]         r_accelCount;
    logic [SEL_W-1:0]   r_accelIdx;
    logic               r_accelDir;
    logic [TIMER_W-1:0] r_accelTimer;
    logic               w_stepTaken;
    logic               w_sameRun;
    logic               w_windowOpen;
    logic [2:0]         w_runLen;

    assign w_stepTaken  = w_encStep & ~(w_wrHit && (bus.wr_idx == bus.param_sel));
    assign w_windowOpen = (32'(r_accelTimer) < ACCEL_WINDOW);
    assign w_sameRun    = (r_accelCount != 3'd0) && (r_accelIdx == bus.param_sel) &&
                          (r_accelDir == w_encIsDec) && w_windowOpen;
    assign w_runLen     = !w_sameRun ? 3'd1 :
                          (r_accelCount == 3'd4) ? 3'd4 : (r_accelCount + 3'd1);
    assign w_step       = (w_runLen >= 3'd4) ? (STEP << 2) : STEP;

    // Run tracker: counts same-direction steps on one index (saturating at 4),
    // restarting on a new index/direction and clearing on a write or timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_accelCount <= 3'd0;
            r_accelIdx   <= '0;
            r_accelDir   <= 1'b0;
            r_accelTimer <= '0;
        end else if (w_stepTaken) begin
            r_accelCount <= w_runLen;
            r_accelIdx   <= bus.param_sel;
            r_accelDir   <= w_encIsDec;
            r_accelTimer <= '0;
        end else begin
            if (w_wrHit && (bus.wr_idx == r_accelIdx)) begin
                r_accelCount <= 3'd0;
            end else if ((r_accelCount != 3'd0) && !w_windowOpen) begin
                r_accelCount <= 3'd0;
            end
            if ((r_accelCount != 3'd0) && w_windowOpen) begin
                r_accelTimer <= r_accelTimer + TIMER_W'(1);
            end
        end
    end
`else
    assign w_step = STEP;
`endif

    // Next value of every register: an HPS write beats an encoder step on the
    // same index; steps saturate at 0 and MAX_VAL using one extra bit of headroom.
    always_comb begin
        for (int i = 0; i < NUM_PARAMS; i++) begin
            w_nextVal[i] = r_regs[i];
            if (w_wrHit && (32'(bus.wr_idx) == i)) begin
                w_nextVal[i] = w_wrClamped;
            end else if (w_encStep && (32'(bus.param_sel) == i)) begin
                if (w_encIsDec) begin
                    w_nextVal[i] = (r_regs[i] < w_step) ? '0 : (r_regs[i] - w_step);
                end else begin
                    w_nextVal[i] = ({1'b0, r_regs[i]} > ({1'b0, MAX_VAL} - {1'b0, w_step})) ?
                                   MAX_VAL : (r_regs[i] + w_step);
                end
            end
            w_changed[i] = (w_nextVal[i] != r_regs[i]);
        end
    end

    // Parameter register bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                r_regs[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < NUM_PARAMS; i++) begin
                r_regs[i] <= w_nextVal[i];
            end
        end
    end

    // Lowest pending index; its data is the value after any same-cycle update.
    always_comb begin
        w_found   = 1'b0;
        w_lowIdx  = '0;
        w_lowData = '0;
        w_lowMask = '0;
        for (int i = NUM_PARAMS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_found      = 1'b1;
                w_lowIdx     = SEL_W'(i);
                w_lowData    = w_nextVal[i];
                w_lowMask    = '0;
                w_lowMask[i] = 1'b1;
            end
        end
    end

    // Emitter next-state: latch a new event only from IDLE, leave PRESENT on handshake.
    always_comb begin
        w_stateNext = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_load      = 1'b1;
                    w_stateNext = PRESENT;
                end
            end
            PRESENT: begin
                if (r_evtValid && bus.evt_ready) begin
                    w_stateNext = IDLE;
                end
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    assign w_clearMask = w_load ? w_lowMask : '0;

    // Emitter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Pending mask: a fresh change re-arms a bit even as it is being consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clearMask) | w_changed;
        end
    end

    // Event output registers, held stable while the consumer is not ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_evtValid <= 1'b0;
            r_evtIdx   <= '0;
            r_evtData  <= '0;
        end else if (w_load) begin
            r_evtValid <= 1'b1;
            r_evtIdx   <= w_lowIdx;
            r_evtData  <= w_lowData;
        end else if ((r_state == PRESENT) && r_evtValid && bus.evt_ready) begin
            r_evtValid <= 1'b0;
        end
    end

    // Flatten the bank so parameter i sits at bits [i*DATA_W +: DATA_W].
    always_comb begin
        w_flat = '0;
        for (int i = 0; i < NUM_PARAMS; i++) begin
            w_flat[i*DATA_W +: DATA_W] = r_regs[i];
        end
    end

    assign bus.param_values = w_flat;
    assign bus.evt_valid    = r_evtValid;
    assign bus.evt_idx      = r_evtIdx;
    assign bus.evt_data     = r_evtData;

endmodule

// File: tb/tb_reverb_param_bank.sv
// Directed bench for reverb_param_bank: a queue of expected events is filled
// as stimulus is driven and drained as the DUT presents events.
module tb_reverb_param_bank;

    typedef struct packed {
        logic [3:0]  idx;
        logic [23:0] data;
    } evt_t;

`ifdef PARAM_ACCEL_EN
    localparam bit ACCEL = 1'b1;
`else
    localparam bit ACCEL = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    evt_t expQ[$];
    int   tests = 0;
    int   fails = 0;

    reverb_param_bank_if #(.NUM_PARAMS(4), .DATA_W(24), .SEL_W(4)) bus ();

    reverb_param_bank dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "[TB] time limit");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [23:0] regVal(input int i);
        return bus.param_values[i*24 +: 24];
    endfunction

    // Pulse update bits for three cycles, then let the synchroniser settle.
    task automatic applyStimulus(input logic [1:0] upd);
        bus.update = upd;
        repeat (3) tick();
        bus.update = 2'b00;
        repeat (3) tick();
    endtask

    task automatic hpsWrite(input logic [3:0] idx, input logic [23:0] data);
        bus.wr_idx  = idx;
        bus.wr_data = data;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    // Wait (bounded) for an event, compare it with the queue head, then accept it.
    task automatic expectEvent(input string tag);
        evt_t e;
        int   waited = 0;
        while (!bus.evt_valid && waited < 20) begin
            tick();
            waited++;
        end
        if (!bus.evt_valid) begin
            tests++;
            fails++;
            $error("[TB] FAIL %s_timeout: observed evt_valid 0, expected 1", tag);
        end else if (expQ.size() == 0) begin
            tests++;
            fails++;
            $error("[TB] FAIL %s_unexpected: observed idx %0h data %0h, expected no event",
                   tag, bus.evt_idx, bus.evt_data);
            bus.evt_ready = 1'b1;
            tick();
            bus.evt_ready = 1'b0;
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_idx"}, 128'(bus.evt_idx), 128'(e.idx));
            checkOutput({tag, "_data"}, 128'(bus.evt_data), 128'(e.data));
            bus.evt_ready = 1'b1;
            tick();
            bus.evt_ready = 1'b0;
        end
    endtask

    task automatic checkNoEvent(input string tag);
        repeat (4) tick();
        checkOutput(tag, 128'(bus.evt_valid), 128'(0));
    endtask

    task automatic checkHeld(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            tick();
            checkOutput({tag, "_valid"}, 128'(bus.evt_valid), 128'(1));
            checkOutput({tag, "_idx"}, 128'(bus.evt_idx), 128'(expQ[0].idx));
            checkOutput({tag, "_data"}, 128'(bus.evt_data), 128'(expQ[0].data));
        end
    endtask

    initial begin
        logic [23:0] model;
        logic [23:0] stepSize;

        reset         = 1'b1;
        bus.param_sel = '0;
        bus.update    = 2'b00;
        bus.wr_en     = 1'b0;
        bus.wr_idx    = '0;
        bus.wr_data   = '0;
        bus.evt_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Reset state
        checkOutput("rst_values", 128'(bus.param_values), 128'({4{24'h800000}}));
        checkOutput("rst_valid", 128'(bus.evt_valid), 128'(0));
        checkOutput("rst_idx", 128'(bus.evt_idx), 128'(0));
        checkOutput("rst_data", 128'(bus.evt_data), 128'(0));

        // Single inc on sel 1 with two-edge synchroniser latency
        bus.param_sel = 4'd1;
        bus.update    = 2'b01;
        tick();
        tick();
        checkOutput("lat_before", 128'(regVal(1)), 128'(24'h800000));
        tick();
        checkOutput("lat_after", 128'(regVal(1)), 128'(24'h810000));
        bus.update = 2'b00;
        repeat (3) tick();
        expQ.push_back('{idx: 4'd1, data: 24'h810000});
        expectEvent("inc1");

        // Upper saturation, no-op at max, lower saturation
        hpsWrite(4'd2, 24'hFFFFF0);
        expQ.push_back('{idx: 4'd2, data: 24'hFFFFF0});
        expectEvent("wr2");
        bus.param_sel = 4'd2;
        applyStimulus(2'b01);
        expQ.push_back('{idx: 4'd2, data: 24'hFFFFFF});
        expectEvent("sat_hi");
        applyStimulus(2'b01);
        checkNoEvent("sat_hi_noevt");
        checkOutput("sat_hi_val", 128'(regVal(2)), 128'(24'hFFFFFF));
        hpsWrite(4'd2, 24'h000005);
        expQ.push_back('{idx: 4'd2, data: 24'h000005});
        expectEvent("wr2_small");
        applyStimulus(2'b10);
        expQ.push_back('{idx: 4'd2, data: 24'h000000});
        expectEvent("sat_lo");
        applyStimulus(2'b10);
        checkNoEvent("sat_lo_noevt");
        checkOutput("sat_lo_val", 128'(regVal(2)), 128'(24'h000000));

        // Write and step on the same index in the same cycle: write wins
        bus.param_sel = 4'd0;
        bus.update    = 2'b01;
        tick();
        tick();
        bus.wr_idx  = 4'd0;
        bus.wr_data = 24'h123456;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en  = 1'b0;
        bus.update = 2'b00;
        repeat (3) tick();
        expQ.push_back('{idx: 4'd0, data: 24'h123456});
        expectEvent("wr_wins");
        checkNoEvent("wr_wins_noevt");
        checkOutput("wr_wins_val", 128'(regVal(0)), 128'(24'h123456));

        // Both directions together, out-of-range select and write index
        applyStimulus(2'b11);
        checkNoEvent("both_noevt");
        bus.param_sel = 4'd9;
        applyStimulus(2'b01);
        checkNoEvent("oor_sel_noevt");
        hpsWrite(4'd7, 24'h777777);
        checkNoEvent("oor_wr_noevt");
        checkOutput("ignored_vals", 128'(bus.param_values),
                    128'({24'h800000, 24'h000000, 24'h810000, 24'h123456}));

        // Step on idx 1 and write on idx 3 in the same cycle: both apply, lowest first
        bus.param_sel = 4'd1;
        bus.update    = 2'b01;
        tick();
        tick();
        bus.wr_idx  = 4'd3;
        bus.wr_data = 24'hABCDEF;
        bus.wr_en   = 1'b1;
        tick();
        bus.wr_en  = 1'b0;
        bus.update = 2'b00;
        repeat (3) tick();
        expQ.push_back('{idx: 4'd1, data: 24'h820000});
        expQ.push_back('{idx: 4'd3, data: 24'hABCDEF});
        expectEvent("dual_a");
        expectEvent("dual_b");

        // Ordering and stability with back-pressure
        hpsWrite(4'd0, 24'h111111);
        expQ.push_back('{idx: 4'd0, data: 24'h111111});
        hpsWrite(4'd3, 24'h333333);
        expQ.push_back('{idx: 4'd3, data: 24'h333333});
        checkHeld("hold0", 4);
        expectEvent("order_a");
        hpsWrite(4'd0, 24'h222222);
        expQ.push_back('{idx: 4'd0, data: 24'h222222});
        checkHeld("hold3", 3);
        expectEvent("order_b");
        expectEvent("order_c");
        checkOutput("order_drained", 128'(expQ.size()), 128'(0));

        // Reset while an event is presented: dropped immediately
        hpsWrite(4'd2, 24'h444444);
        tick();
        checkOutput("mid_valid", 128'(bus.evt_valid), 128'(1));
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_valid", 128'(bus.evt_valid), 128'(0));
        checkOutput("mid_rst_values", 128'(bus.param_values), 128'({4{24'h800000}}));
        expQ.delete();
        tick();
        reset = 1'b0;
        tick();
        checkNoEvent("post_rst_noevt");

        // Five incs then a dec on sel 1 (accelerated when the feature is built)
        bus.param_sel = 4'd1;
        model = 24'h800000;
        for (int n = 0; n < 5; n++) begin
            stepSize = (ACCEL && n >= 3) ? 24'h040000 : 24'h010000;
            model = model + stepSize;
            applyStimulus(2'b01);
            expQ.push_back('{idx: 4'd1, data: model});
            expectEvent("run_inc");
        end
        checkOutput("run_final", 128'(regVal(1)), ACCEL ? 128'(24'h8B0000) : 128'(24'h850000));
        model = model - 24'h010000;
        applyStimulus(2'b10);
        expQ.push_back('{idx: 4'd1, data: model});
        expectEvent("run_dec");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/reverb_param_bank.md
Name: reverb_param_bank

Overview:
- Parametrised bank of NUM_PARAMS reverb control registers, each DATA_W bits wide. Successor to the fixed set of 24-bit decay/damping/mix/predelay PIO registers.
- Registers are stepped by synchronised encoder inc/dec pulses on the selected parameter, or written directly by the HPS.
- Every value change is reported on a ready/valid event stream so software and DSP consumers see each change once, in order.

Parameters:
- NUM_PARAMS, 4, number of parameter registers.
- DATA_W, 24, width of each parameter value.
- SEL_W, 4, width of param_sel and wr_idx; must satisfy 2^SEL_W >= NUM_PARAMS.
- STEP, 24'h010000, increment/decrement per encoder event.
- MAX_VAL, 24'hFFFFFF, upper saturation bound; lower bound is 0.
- RESET_VAL, 24'h800000, value of every register after reset.
- ACCEL_WINDOW, 2_000_000, cycle window for the acceleration feature.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- param_sel  in  SEL_W  parameter targeted by encoder updates (paramtype)
- update  in  2  asynchronous encoder pulses; bit0 = inc, bit1 = dec
- wr_en  in  1  HPS direct-write strobe
- wr_idx  in  SEL_W  HPS write index
- wr_data  in  DATA_W  HPS write value
- param_values  out  NUM_PARAMS*DATA_W  flat register bank; parameter i occupies bits [i*DATA_W +: DATA_W]
- evt_valid  out  1  change event available
- evt_ready  in  1  consumer accepts event
- evt_idx  out  SEL_W  index of the changed parameter
- evt_data  out  DATA_W  new value of that parameter

Behaviour:
- Reset (async assert, sync release):
  - all registers = RESET_VAL
  - pending mask = 0
  - evt_valid = 0, evt_idx = 0, evt_data = 0
  - synchronisers = 0
  - acceleration counters = 0
- Synchronisation: each update bit passes through 2 flops (s1, s2), then a history flop s3. rise_inc = s2&~s3; rise_dec likewise.
  - Input high before edge k: s1 at k, s2 at k+1; register updated at edge k+2.
- Encoder event handling:
  - One rise only: step the parameter at param_sel.
  - rise_inc and rise_dec in the same cycle: ignore both.
  - param_sel >= NUM_PARAMS: ignore.
- Saturating arithmetic, evaluated at DATA_W+1 bits:
  - inc: v > MAX_VAL-STEP gives MAX_VAL, else v+STEP.
  - dec: v < STEP gives 0, else v-STEP.
- HPS write:
  - wr_en with wr_idx < NUM_PARAMS: reg[wr_idx] <= min(wr_data, MAX_VAL) on the next edge.
  - wr_idx out of range: ignored.
  - Same cycle as an encoder step on the same index: the write wins and the step is dropped. Different indices: both apply.
- Change detection: pending[i] is set on the update edge only if the new value differs from the old value. Saturated no-op steps and writes of an identical value produce no event.
- Event emitter, states IDLE / PRESENT:
  - IDLE: if pending != 0, select the lowest set index j. Latch evt_idx = j and evt_data = reg[j] (the value after any same-cycle update), clear pending[j], assert evt_valid, go to PRESENT.
  - PRESENT: evt_idx, evt_data and evt_valid are held stable until evt_valid&evt_ready, then return to IDLE.
  - Zero-bubble option: an emitter that re-latches directly from PRESENT is permitted, with identical ordering.
  - If reg[j] changes while its event is held, pending[j] is set again, so a further event with the newer value follows.
  - A set and a clear of pending[j] in the same cycle: set wins.
- Latency: register change at edge n gives evt_valid at edge n+1, provided the emitter is IDLE and no lower index is pending.
- Reset mid-handshake: the event is lost and evt_valid drops immediately (async).

Optional Feature:
- Macro: PARAM_ACCEL_EN.
- Defined:
  - A per-bank counter tracks consecutive encoder steps of the same direction on the same index, each within ACCEL_WINDOW cycles of the previous one.
  - From the 4th such step onward the step becomes STEP<<2, with the same saturation rules.
  - A direction change, index change, HPS write to that index, or window timeout resets the count to 0.
- Not defined: the step is always STEP; the counter and window timer are not built.

Test Plan:
- Reset, then read all regs -> param_values = {4{24'h800000}}, evt_valid = 0.
- param_sel = 1, one update[0] pulse -> reg1 = 24'h810000 exactly 2 edges after the input is sampled high; event idx=1, data=24'h810000.
- HPS write reg2 = 24'hFFFFF0, then inc on sel 2 -> reg2 = 24'hFFFFFF with one event. A second inc -> no change, no event. Writing 24'h000005 then dec -> reg2 = 0.
- Same cycle: wr_en idx0 = 24'h123456 and inc on sel 0 -> reg0 = 24'h123456. Both update bits rising together -> no change.
- Hold evt_ready = 0, change reg0 then reg3, then reg0 again -> events drained in order: (0, first value), (3, ...), (0, newest value). evt fields stay stable while not ready.
- PARAM_ACCEL_EN: 5 inc pulses within the window -> steps of 0x010000 x3, then 0x040000 x2 -> reg = 24'h8B0000. A dec pulse resets the count.
